alu_exec_unit: RTL and testbench

//   Parametrised successor to the ALU control decoder. Decodes ALUOp/funct3/funct7[5] into the full RV32I

---
 rtl/alu_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for RV32I integer ops. ALUOp/funct3/funct7[5] decode and valid/ready handshakes.
// Shifts run iteratively, advancing up to SHIFT_STEP bit positions per cycle.
module alu_exec_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] STEP_W = SHW'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_PASS
    } op_t;

    state_t          state_q, state_d;
    op_t             op_dec, sh_op_q, sh_op_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  rem_q, rem_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  shamt, step;
    logic [XLEN-1:0] alu_res, shifted;
    logic            is_shift;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        op_dec = OP_ADD;
        case (alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            default: begin
                case (funct3)
                    3'b000: op_dec = (alu_op == 2'b10 && funct7_5) ? OP_SUB : OP_ADD;
                    3'b001: op_dec = OP_SLL;
                    3'b010: op_dec = OP_SLT;
                    3'b011: op_dec = OP_SLTU;
                    3'b100: op_dec = OP_XOR;
                    3'b101: op_dec = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110: op_dec = OP_OR;
                    default: op_dec = OP_AND;
                endcase
                // R-type with bit 30 set is only defined for SUB and SRA
                if (alu_op == 2'b10 && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) begin
                    op_dec = OP_PASS;
                end
            end
        endcase
    end

    assign is_shift = (op_dec == OP_SLL) || (op_dec == OP_SRL) || (op_dec == OP_SRA);

    // Shifts reach here only with shamt=0, so they pass op_a straight through
    always_comb begin
        alu_res = op_a;
        case (op_dec)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_PASS: alu_res = op_b;
            default: alu_res = op_a;
        endcase
    end

    assign step = (rem_q < STEP_W) ? rem_q : STEP_W;

    // Small mux over 0..SHIFT_STEP positions instead of a full barrel shifter
    always_comb begin
        shifted = work_q;
        for (int unsigned k = 0; k <= SHIFT_STEP; k++) begin
            if (step == SHW'(k)) begin
                case (sh_op_q)
                    OP_SLL:  shifted = work_q << k;
                    OP_SRA:  shifted = $signed(work_q) >>> k;
                    default: shifted = work_q >> k;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        rem_d     = rem_q;
        sh_op_d   = sh_op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && shamt != '0) begin
                        work_d  = op_a;
                        rem_d   = shamt;
                        sh_op_d = op_dec;
                        state_d = SHIFT;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = (op_dec == OP_PASS);
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step;
                if (rem_q == step) begin
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            rem_q     <= '0;
            sh_op_q   <= OP_ADD;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            sh_op_q   <= sh_op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors with literal expectations, plus a cycle-level
// reference model compared against the DUT on every negative clock edge.
module tb_alu_exec_unit;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, funct7_5 = 1'b0, out_valid, out_ready = 1'b0, zero, illegal;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0, result;

    logic        in_valid4 = 1'b0, in_ready4, funct7_5_4 = 1'b0, out_valid4, out_ready4 = 1'b0, zero4, illegal4;
    logic [1:0]  alu_op4 = '0;
    logic [2:0]  funct3_4 = '0;
    logic [31:0] op_a4 = '0, op_b4 = '0, result4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_op(alu_op4), .funct3(funct3_4), .funct7_5(funct7_5_4), .op_a(op_a4), .op_b(op_b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .zero(zero4), .illegal(illegal4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b, output logic ill);
        logic [4:0] sh;
        sh  = b[4:0];
        ill = 1'b0;
        if (aop == 2'b00) return a + b;
        if (aop == 2'b01) return a - b;
        if (aop == 2'b10 && f7 && f3 != 3'd0 && f3 != 3'd5) begin
            ill = 1'b1;
            return b;
        end
        case (f3)
            3'd0: return (aop == 2'b10 && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] b, input int stp);
        int sh;
        bit shift_op;
        sh = int'(b[4:0]);
        shift_op = aop[1] && (f3 == 3'd1 || f3 == 3'd5) && !(aop == 2'b10 && f7 && f3 == 3'd1);
        if (!shift_op || sh == 0) return 1;
        return 1 + (sh + stp - 1) / stp;
    endfunction

    // Reference model: idle / busy countdown / result pending
    logic [31:0] m_res = '0;
    logic        m_ill = 1'b0;
    int          m_cnt = 0;
    bit          m_busy = 1'b0, m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        int lat;
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (in_valid) begin
            m_res = ref_alu(alu_op, funct3, funct7_5, op_a, op_b, m_ill);
            lat = ref_lat(alu_op, funct3, funct7_5, op_b, STEP);
            if (lat == 1) m_done = 1'b1;
            else begin
                m_cnt  = lat - 1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("mdl_in_ready", in_ready, !(m_busy || m_done));
            check("mdl_out_valid", out_valid, m_done);
            if (m_done) begin
                check("mdl_result", result, m_res);
                check("mdl_zero", zero, m_res == 0);
                check("mdl_illegal", illegal, m_ill);
            end
        end
    end

    task automatic run_op(input string nm, input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                          input logic ei, input int el, input bit early);
        int lat;
        @(negedge clk);
        check({nm, "_ready"}, in_ready, 1);
        in_valid = 1'b1; alu_op = aop; funct3 = f3; funct7_5 = f7; op_a = a; op_b = b;
        out_ready = early;
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); funct7_5 = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, lat, el);
        check({nm, "_res"}, result, er);
        check({nm, "_zero"}, zero, er == 0);
        check({nm, "_ill"}, illegal, ei);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run4(input string nm, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input int el);
        int lat;
        @(negedge clk);
        in_valid4 = 1'b1; alu_op4 = 2'b10; funct3_4 = f3; funct7_5_4 = f7; op_a4 = a; op_b4 = b;
        @(negedge clk);
        in_valid4 = 1'b0; op_a4 = $urandom; op_b4 = $urandom;
        lat = 1;
        while (!out_valid4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, lat, el);
        check({nm, "_res"}, result4, er);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check({nm, "_idle"}, in_ready4, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run_op("add_wrap", 2'b10, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b0);
        run_op("sub",      2'b10, 3'd0, 1'b1, 32'h1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1, 1'b0);
        run_op("slt",      2'b10, 3'd2, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 1'b0);
        run_op("sltu",     2'b10, 3'd3, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 1'b0);
        run_op("op01_sub", 2'b01, 3'd7, 1'b1, 32'h5, 32'h5, 32'h0, 1'b0, 1, 1'b0);
        run_op("sra4",     2'b10, 3'd5, 1'b1, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 5, 1'b0);
        run_op("srl4",     2'b10, 3'd5, 1'b0, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 5, 1'b1);
        run_op("sra_sh0",  2'b10, 3'd5, 1'b1, 32'h8000_0000, 32'h20, 32'h8000_0000, 1'b0, 1, 1'b0);
        run_op("slli31",   2'b11, 3'd1, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32, 1'b0);
        run_op("srai8",    2'b11, 3'd5, 1'b1, 32'hF000_0000, 32'd8, 32'hFFF0_0000, 1'b0, 9, 1'b0);
        run_op("illegal",  2'b10, 3'd6, 1'b1, 32'hDEAD_BEEF, 32'h1234, 32'h0000_1234, 1'b1, 1, 1'b0);
        run_op("xor",      2'b10, 3'd4, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1, 1'b0);
        run_op("ori_f7",   2'b11, 3'd6, 1'b1, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1, 1'b0);
        run_op("and",      2'b10, 3'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1, 1'b0);
        run_op("addi_f7",  2'b11, 3'd0, 1'b1, 32'h10, 32'h5, 32'h15, 1'b0, 1, 1'b0);
        run_op("sll_ill",  2'b10, 3'd1, 1'b1, 32'h1, 32'h3, 32'h3, 1'b1, 1, 1'b0);

        // Backpressure with a competing request held on the inputs
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd0; funct7_5 = 1'b0; op_a = 32'd100; op_b = 32'd23;
        @(negedge clk);
        alu_op = 2'b00; op_a = 32'd7; op_b = 32'd7;
        check("bp_valid", out_valid, 1);
        check("bp_result", result, 32'd123);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_result", result, 32'd123);
            check("bp_hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);

        // Reset in the middle of a long shift
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd1; funct7_5 = 1'b0; op_a = 32'h1; op_b = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", in_ready, 0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 0);
        check("mid_rst_illegal", illegal, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_result", out_valid, 0);
        run_op("post_rst_add", 2'b00, 3'd0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1, 1'b0);

        run4("s4_sra4",  3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 2);
        run4("s4_srl6",  3'd5, 1'b0, 32'h8000_0000, 32'd6, 32'h0200_0000, 3);
        run4("s4_sll31", 3'd1, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 9);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
